efb_wb_arb: RTL and testbench

- Wishbone bus controller for the EFB (SPI/I2C/UFM hard block), driven from clk_USB.
- After reset it issues one boot write to the EFB configuration register (default 0x55 <= 0xE0). It then shares the single EFB Wishbone slave port between two requesters, A and B, using round-robin arbitration.
- A watchdog terminates any access the EFB never acknowledges, so a requester cannot hang the bus.

---
 rtl/efb_pkg.sv | 24 ++
 rtl/efb_wb_wdog.sv | 34 +++
 rtl/efb_wb_arb.sv | 185 ++++++++++++++++++
 tb/tb_efb_wb_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/efb_pkg.sv
// rtl/efb_pkg.sv - shared EFB Wishbone types and register map
// Purpose: FSM state encodings, EFB register addresses and the boot configuration value.
// Ports: none (package).
package efb_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_BACC,
    ST_IDLE,
    ST_ACC,
    ST_GAP
  } efb_state_t;

  // EFB register map (configuration plus I2C/SPI control registers)
  localparam logic [7:0] EFB_ADDR_CFG     = 8'h55;
  localparam logic [7:0] EFB_ADDR_I2C1_CR = 8'h40;
  localparam logic [7:0] EFB_ADDR_I2C2_CR = 8'h4A;
  localparam logic [7:0] EFB_ADDR_SPI_CR0 = 8'h56;
  localparam logic [7:0] EFB_ADDR_SPI_CR1 = 8'h57;
  localparam logic [7:0] EFB_ADDR_SPI_CR2 = 8'h58;

  localparam logic [7:0] EFB_BOOT_DATA    = 8'hE0;

endpackage

// File: rtl/efb_wb_wdog.sv
// rtl/efb_wb_wdog.sv - Wishbone access watchdog
// Purpose: counts cycles of an unacknowledged access and flags the terminal count.
// Ports: clk, rst (async active-low), clr (restart count), en (count this cycle),
//        tc (terminal count reached in the current cycle).
module efb_wb_wdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // cnt holds the number of already-elapsed unacknowledged cycles, so the
  // TIMEOUT-th cycle of a stalled access is the one where cnt == TIMEOUT-1.
  localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/efb_wb_arb.sv
// rtl/efb_wb_arb.sv - EFB Wishbone master with boot write and round-robin A/B arbitration
// Purpose: issues one boot write after reset, then shares the EFB slave port between
//          requesters A and B with a watchdog terminating unacknowledged accesses.
// Ports: clk, rst (async active-low);
//        a_/b_ req, we, adr, wdat (in), ack, err (out, 1-cycle pulses);
//        rdat (read data, valid with ack); wb_cyc_o/stb_o/we_o/adr_o/dat_o, wb_dat_i, wb_ack_i;
//        boot_done, boot_err (sticky boot status).
module efb_wb_arb
  import efb_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                TIMEOUT   = 255,
  parameter int                TO_W      = 8,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = ADDR_W'(EFB_ADDR_CFG),
  parameter logic [DATA_W-1:0] BOOT_DATA = DATA_W'(EFB_BOOT_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_adr,
  input  logic [DATA_W-1:0] a_wdat,
  output logic              a_ack,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_adr,
  input  logic [DATA_W-1:0] b_wdat,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] rdat,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic              boot_done,
  output logic              boot_err
);

  efb_state_t        state, state_n;
  logic              ptr_b, ptr_b_n;   // 1: B wins the next tie
  logic              gnt_b, gnt_b_n;   // requester owning the current access
  logic              take_b;
  logic              cyc_n, we_n;
  logic [ADDR_W-1:0] adr_n;
  logic [DATA_W-1:0] dat_n, rdat_n;
  logic              a_ack_n, a_err_n, b_ack_n, b_err_n;
  logic              boot_done_n, boot_err_n;
  logic              wd_clr, wd_en, wd_tc;

  // Counter sits at zero whenever no access is in flight, so it is fresh on entry.
  assign wd_clr = (state != ST_ACC) && (state != ST_BACC);
  assign wd_en  = wb_cyc_o && !wb_ack_i;

  efb_wb_wdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr),
    .en  (wd_en),
    .tc  (wd_tc)
  );

  always_comb begin
    state_n     = state;
    ptr_b_n     = ptr_b;
    gnt_b_n     = gnt_b;
    take_b      = 1'b0;
    cyc_n       = wb_cyc_o;
    we_n        = wb_we_o;
    adr_n       = wb_adr_o;
    dat_n       = wb_dat_o;
    rdat_n      = rdat;
    a_ack_n     = 1'b0;
    a_err_n     = 1'b0;
    b_ack_n     = 1'b0;
    b_err_n     = 1'b0;
    boot_done_n = boot_done;
    boot_err_n  = boot_err;

    case (state)
      ST_BOOT: begin
        state_n = ST_BACC;
        cyc_n   = 1'b1;
        we_n    = 1'b1;
        adr_n   = BOOT_ADDR;
        dat_n   = BOOT_DATA;
      end

      ST_BACC: begin
        // ack is tested first so it wins over a coincident terminal count
        if (wb_ack_i) begin
          state_n     = ST_GAP;
          cyc_n       = 1'b0;
          boot_done_n = 1'b1;
        end else if (wd_tc) begin
          state_n     = ST_GAP;
          cyc_n       = 1'b0;
          boot_done_n = 1'b1;
          boot_err_n  = 1'b1;
        end
      end

      ST_IDLE: begin
        if (a_req || b_req) begin
          take_b  = b_req && (!a_req || ptr_b);
          gnt_b_n = take_b;
          ptr_b_n = !take_b;
          state_n = ST_ACC;
          cyc_n   = 1'b1;
          we_n    = take_b ? b_we   : a_we;
          adr_n   = take_b ? b_adr  : a_adr;
          dat_n   = take_b ? b_wdat : a_wdat;
        end
      end

      ST_ACC: begin
        if (wb_ack_i) begin
          state_n = ST_GAP;
          cyc_n   = 1'b0;
          rdat_n  = wb_dat_i;
          a_ack_n = !gnt_b;
          b_ack_n = gnt_b;
        end else if (wd_tc) begin
          state_n = ST_GAP;
          cyc_n   = 1'b0;
          a_err_n = !gnt_b;
          b_err_n = gnt_b;
        end
      end

      ST_GAP: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_BOOT;
        cyc_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_BOOT;
      ptr_b     <= 1'b0;
      gnt_b     <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      rdat      <= '0;
      a_ack     <= 1'b0;
      a_err     <= 1'b0;
      b_ack     <= 1'b0;
      b_err     <= 1'b0;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      state     <= state_n;
      ptr_b     <= ptr_b_n;
      gnt_b     <= gnt_b_n;
      wb_cyc_o  <= cyc_n;
      wb_stb_o  <= cyc_n;
      wb_we_o   <= we_n;
      wb_adr_o  <= adr_n;
      wb_dat_o  <= dat_n;
      rdat      <= rdat_n;
      a_ack     <= a_ack_n;
      a_err     <= a_err_n;
      b_ack     <= b_ack_n;
      b_err     <= b_err_n;
      boot_done <= boot_done_n;
      boot_err  <= boot_err_n;
    end
  end

endmodule

// File: tb/tb_efb_wb_arb.sv
// tb/tb_efb_wb_arb.sv - scoreboard bench for efb_wb_arb
module tb_efb_wb_arb;
  import efb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_adr, a_wdat, b_adr, b_wdat;
  logic       a_ack, a_err, b_ack, b_err;
  logic [7:0] rdat;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0] wb_adr_o, wb_dat_o;
  logic [7:0] wb_dat_i = 8'h00;
  logic       wb_ack_i = 1'b0;
  logic       boot_done, boot_err;

  int checks = 0;
  int errors = 0;

  int         ack_lat = 3;      // slave acks in this cycle of cyc (0: never)
  logic [7:0] rd_data = 8'h00;
  int         scnt = 0;

  typedef struct packed {logic we; logic [7:0] adr; logic [7:0] dat;} bus_t;
  typedef struct packed {logic is_b; logic is_err; logic [7:0] rdat;} rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t exp_b;
  rsp_t exp_r;

  int   cyc_len = 0;
  int   last_cyc_len = 0;
  int   idle_len = 0;
  logic cyc_prev = 1'b0;

  always #5 clk = ~clk;

  efb_wb_arb #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .TIMEOUT   (8),
    .TO_W      (8),
    .BOOT_ADDR (8'h55),
    .BOOT_DATA (8'hE0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_adr     (a_adr),
    .a_wdat    (a_wdat),
    .a_ack     (a_ack),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_adr     (b_adr),
    .b_wdat    (b_wdat),
    .b_ack     (b_ack),
    .b_err     (b_err),
    .rdat      (rdat),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model: ack during the ack_lat-th cycle that cyc is high.
  always @(negedge clk) begin
    if (wb_cyc_o === 1'b1) scnt = scnt + 1;
    else scnt = 0;
    wb_ack_i = (wb_cyc_o === 1'b1) && (ack_lat != 0) && (scnt == ack_lat);
    wb_dat_i = rd_data;
  end

  // Monitor: bus transfers and responses are popped from the scoreboard as they appear.
  always @(negedge clk) begin
    if (wb_cyc_o === 1'b1) begin
      if (!cyc_prev) begin
        chk("gap_before_cyc", 32'(idle_len >= 2), 1);
        chk("stb_eq_cyc", 32'(wb_stb_o), 1);
        checks++;
        assert (bus_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_cyc: observed adr %0h expected no access", wb_adr_o);
        end
        if (bus_q.size() != 0) begin
          exp_b = bus_q.pop_front();
          chk("bus_xfer", 32'({wb_we_o, wb_adr_o, wb_dat_o}), 32'(exp_b));
        end
        cyc_len = 0;
      end
      cyc_len++;
      idle_len = 0;
    end else begin
      if (cyc_prev) last_cyc_len = cyc_len;
      idle_len++;
    end
    cyc_prev = (wb_cyc_o === 1'b1);

    if ((a_ack | a_err | b_ack | b_err) === 1'b1) begin
      chk("pulse_onehot", 32'($countones({a_ack, a_err, b_ack, b_err})), 1);
      checks++;
      assert (rsp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rsp: observed %b expected none", {a_ack, a_err, b_ack, b_err});
      end
      if (rsp_q.size() != 0) begin
        exp_r = rsp_q.pop_front();
        chk("rsp", 32'({b_ack | b_err, a_err | b_err, rdat}), 32'(exp_r));
      end
    end
  end

  task automatic wait_boot(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (boot_done === 1'b1);
    end
    chk({tag, "_done"}, 32'(seen), 1);
  endtask

  task automatic wait_pulse(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = ((a_ack | a_err | b_ack | b_err) === 1'b1);
    end
    chk({tag, "_pulse"}, 32'(seen), 1);
  endtask

  initial begin
    int  na, nb;
    bit  seen;
    rst = 1'b1;
    a_req = 0; a_we = 0; a_adr = 0; a_wdat = 0;
    b_req = 0; b_we = 0; b_adr = 0; b_wdat = 0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_cyc", 32'(wb_cyc_o), 0);
    chk("rst_boot_done", 32'(boot_done), 0);
    chk("rst_boot_err", 32'(boot_err), 0);
    chk("rst_pulses", 32'({a_ack, a_err, b_ack, b_err}), 0);
    chk("rst_rdat", 32'(rdat), 0);
    chk("rst_adr", 32'(wb_adr_o), 0);

    // boot write, slave acks 2 cycles after stb
    ack_lat = 3;
    bus_q.push_back(bus_t'{we: 1'b1, adr: 8'h55, dat: 8'hE0});
    rst = 1'b1;
    wait_boot("boot");
    chk("boot_err", 32'(boot_err), 0);
    chk("boot_cyc_low", 32'(wb_cyc_o), 0);
    @(negedge clk);
    chk("boot_cyc_len", 32'(last_cyc_len), 3);
    chk("boot_rdat_kept", 32'(rdat), 0);

    // single read by A
    rd_data = 8'hA5; ack_lat = 1;
    a_we = 0; a_adr = 8'h54; a_wdat = 8'h00; a_req = 1;
    bus_q.push_back(bus_t'{we: 1'b0, adr: 8'h54, dat: 8'h00});
    rsp_q.push_back(rsp_t'{is_b: 1'b0, is_err: 1'b0, rdat: 8'hA5});
    wait_pulse("a_read");
    a_req = 0;
    chk("a_read_ack", 32'(a_ack), 1);
    chk("a_read_b_quiet", 32'({b_ack, b_err}), 0);
    @(negedge clk);
    chk("a_ack_one_cycle", 32'(a_ack), 0);

    // single write by B; rdat still takes wb_dat_i
    rd_data = 8'h11;
    b_we = 1; b_adr = 8'h40; b_wdat = 8'h3C; b_req = 1;
    bus_q.push_back(bus_t'{we: 1'b1, adr: 8'h40, dat: 8'h3C});
    rsp_q.push_back(rsp_t'{is_b: 1'b1, is_err: 1'b0, rdat: 8'h11});
    wait_pulse("b_write");
    b_req = 0;
    repeat (2) @(negedge clk);

    // contention: both held, expect A,B,A,B
    rd_data = 8'h77;
    a_we = 1; a_adr = 8'h56; a_wdat = 8'h12;
    b_we = 0; b_adr = 8'h4A; b_wdat = 8'h00;
    for (int i = 0; i < 2; i++) begin
      bus_q.push_back(bus_t'{we: 1'b1, adr: 8'h56, dat: 8'h12});
      bus_q.push_back(bus_t'{we: 1'b0, adr: 8'h4A, dat: 8'h00});
      rsp_q.push_back(rsp_t'{is_b: 1'b0, is_err: 1'b0, rdat: 8'h77});
      rsp_q.push_back(rsp_t'{is_b: 1'b1, is_err: 1'b0, rdat: 8'h77});
    end
    a_req = 1; b_req = 1;
    na = 0; nb = 0;
    for (int i = 0; i < 100 && !(na == 2 && nb == 2); i++) begin
      @(negedge clk);
      if (a_ack === 1'b1) begin na++; if (na == 2) a_req = 0; end
      if (b_ack === 1'b1) begin nb++; if (nb == 2) b_req = 0; end
    end
    a_req = 0; b_req = 0;
    chk("contend_a_count", 32'(na), 2);
    chk("contend_b_count", 32'(nb), 2);
    repeat (3) @(negedge clk);
    chk("contend_rsp_drained", 32'(rsp_q.size()), 0);

    // ack on the terminal-count cycle: ack wins
    rd_data = 8'hC3; ack_lat = 8;
    a_we = 0; a_adr = 8'h57; a_wdat = 8'h00; a_req = 1;
    bus_q.push_back(bus_t'{we: 1'b0, adr: 8'h57, dat: 8'h00});
    rsp_q.push_back(rsp_t'{is_b: 1'b0, is_err: 1'b0, rdat: 8'hC3});
    wait_pulse("collide");
    a_req = 0;
    chk("collide_no_err", 32'(a_err), 0);
    @(negedge clk);
    chk("collide_cyc_len", 32'(last_cyc_len), 8);

    // B never acknowledged: err pulse, rdat unchanged
    rd_data = 8'h99; ack_lat = 0;
    b_we = 0; b_adr = 8'h4B; b_wdat = 8'h00; b_req = 1;
    bus_q.push_back(bus_t'{we: 1'b0, adr: 8'h4B, dat: 8'h00});
    rsp_q.push_back(rsp_t'{is_b: 1'b1, is_err: 1'b1, rdat: 8'hC3});
    wait_pulse("b_timeout");
    b_req = 0;
    chk("b_timeout_err", 32'(b_err), 1);
    @(negedge clk);
    chk("b_timeout_cyc_len", 32'(last_cyc_len), 8);

    // reset in the middle of an access
    a_we = 0; a_adr = 8'h42; a_wdat = 8'h00; a_req = 1;
    bus_q.push_back(bus_t'{we: 1'b0, adr: 8'h42, dat: 8'h00});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (wb_cyc_o === 1'b1);
    end
    chk("midrst_cyc_seen", 32'(seen), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_cyc_drop", 32'(wb_cyc_o), 0);
    chk("midrst_stb_drop", 32'(wb_stb_o), 0);
    a_req = 0; ack_lat = 3;
    bus_q.push_back(bus_t'{we: 1'b1, adr: 8'h55, dat: 8'hE0});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_boot("reboot");
    chk("reboot_err", 32'(boot_err), 0);
    chk("reboot_rdat", 32'(rdat), 0);
    @(negedge clk);
    chk("reboot_cyc_len", 32'(last_cyc_len), 3);

    // boot timeout with A pending
    rst = 1'b0; ack_lat = 0;
    a_we = 1; a_adr = 8'h41; a_wdat = 8'h99; a_req = 1;
    bus_q.push_back(bus_t'{we: 1'b1, adr: 8'h55, dat: 8'hE0});
    bus_q.push_back(bus_t'{we: 1'b1, adr: 8'h41, dat: 8'h99});
    rsp_q.push_back(rsp_t'{is_b: 1'b0, is_err: 1'b0, rdat: 8'h5A});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_boot("boot_to");
    chk("boot_to_err", 32'(boot_err), 1);
    ack_lat = 1; rd_data = 8'h5A;
    @(negedge clk);
    chk("boot_to_cyc_len", 32'(last_cyc_len), 8);
    wait_pulse("boot_to_a");
    a_req = 0;
    chk("boot_to_a_ack", 32'(a_ack), 1);
    chk("boot_err_sticky", 32'(boot_err), 1);

    repeat (5) @(negedge clk);
    chk("bus_q_empty", 32'(bus_q.size()), 0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
